// File: rtl/stopwatch_timer_core_if.sv
// stopwatch_timer_core_if: strobes, buttons and switches in; display fields and status flags out.
interface stopwatch_timer_core_if #(parameter int W = 6);
    logic         tick;
    logic         adj_tick;
    logic         pause_btn;
    logic         lap_btn;
    logic         adj;
    logic         sel;
    logic         down;
    logic [W-1:0] min_out;
    logic [W-1:0] sec_out;
    logic         running;
    logic         lapped;
    logic         expired;
    logic         wrap;

    modport master (
        output tick, adj_tick, pause_btn, lap_btn, adj, sel, down,
        input  min_out, sec_out, running, lapped, expired, wrap
    );

    modport slave (
        input  tick, adj_tick, pause_btn, lap_btn, adj, sel, down,
        output min_out, sec_out, running, lapped, expired, wrap
    );
endinterface

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: min:sec up/down stopwatch with adjust mode, lap freeze, wrap pulse and expiry.
module stopwatch_timer_core #(
    parameter int W       = 6,
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    stopwatch_timer_core_if.slave   bus
);
    localparam logic [W-1:0] SEC_MAX = W'(SEC_MOD - 1);
    localparam logic [W-1:0] MIN_MAX = W'(MIN_MOD - 1);

    typedef enum logic [1:0] {PAUSED, RUN, ADJ, DONE} state_t;

    state_t       state, state_n;
    logic [W-1:0] min_c, sec_c, min_n, sec_n;
    logic [W-1:0] inc_min, inc_sec;
    logic         pause_q, lap_q;
    logic         pause_edge, lap_edge;
    logic         sec_top, min_top, at_zero;
    logic         lap_n, wrap_n;

    assign pause_edge = bus.pause_btn & ~pause_q;
    assign lap_edge   = bus.lap_btn & ~lap_q;
    // >= rather than == keeps fields in range even for odd parameter choices
    assign sec_top    = sec_c >= SEC_MAX;
    assign min_top    = min_c >= MIN_MAX;
    assign inc_sec    = sec_top ? '0 : sec_c + 1'b1;
    assign inc_min    = min_top ? '0 : min_c + 1'b1;
    assign at_zero    = (min_c == '0) && (sec_c == '0);
    assign lap_n      = (bus.adj || state == ADJ) ? 1'b0 : bus.lapped ^ lap_edge;

    always_comb begin
        state_n = state;
        min_n   = min_c;
        sec_n   = sec_c;
        wrap_n  = 1'b0;
        if (bus.adj) begin
            state_n = ADJ;
            if (bus.adj_tick) begin
                min_n = bus.sel ? min_c : inc_min;
                sec_n = bus.sel ? inc_sec : sec_c;
            end
        end else begin
            case (state)
                ADJ:    state_n = PAUSED;
                PAUSED: state_n = pause_edge ? RUN : PAUSED;
                DONE:   state_n = pause_edge ? PAUSED : DONE;
                RUN: begin
                    if (pause_edge) begin
                        state_n = PAUSED;
                    end else if (bus.tick && !bus.down) begin
                        sec_n  = inc_sec;
                        min_n  = sec_top ? inc_min : min_c;
                        wrap_n = sec_top & min_top;
                    end else if (bus.tick && at_zero) begin
                        state_n = DONE;
                    end else if (bus.tick) begin
                        sec_n   = (sec_c == '0) ? SEC_MAX : sec_c - 1'b1;
                        min_n   = (sec_c == '0) ? min_c - 1'b1 : min_c;
                        state_n = (min_c == '0 && sec_c == W'(1)) ? DONE : RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        pause_q <= bus.pause_btn;
        lap_q   <= bus.lap_btn;
        if (rst) begin
            state       <= PAUSED;
            min_c       <= '0;
            sec_c       <= '0;
            bus.min_out <= '0;
            bus.sec_out <= '0;
            bus.running <= 1'b0;
            bus.lapped  <= 1'b0;
            bus.expired <= 1'b0;
            bus.wrap    <= 1'b0;
        end else begin
            state       <= state_n;
            min_c       <= min_n;
            sec_c       <= sec_n;
            // a held lap keeps the frozen value; otherwise the display follows the live count
            bus.min_out <= (lap_n && bus.lapped) ? bus.min_out : min_n;
            bus.sec_out <= (lap_n && bus.lapped) ? bus.sec_out : sec_n;
            bus.running <= state_n == RUN;
            bus.lapped  <= lap_n;
            bus.expired <= state_n == DONE;
            bus.wrap    <= wrap_n;
        end
    end
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: directed stimulus pushes expected observations; a negedge monitor pops and compares.
module tb_stopwatch_timer_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stopwatch_timer_core_if #(.W(6)) bus();

    stopwatch_timer_core #(.W(6), .SEC_MOD(60), .MIN_MOD(60)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] s;
        logic       run;
        logic       lap;
        logic       ex;
        logic       wr;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always @(negedge clk) begin
        obs_t  got;
        obs_t  want;
        string nm;
        got = {bus.min_out, bus.sec_out, bus.running, bus.lapped, bus.expired, bus.wrap};
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d run=%b lap=%b exp=%b wrap=%b, want %0d:%0d run=%b lap=%b exp=%b wrap=%b",
                         nm, got.m, got.s, got.run, got.lap, got.ex, got.wr,
                         want.m, want.s, want.run, want.lap, want.ex, want.wr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.tick     = 1'b0;
        bus.adj_tick = 1'b0;
    endtask

    task automatic chk(string nm, int m, int s, bit run, bit lap, bit ex, bit wr);
        exp_q.push_back({6'(m), 6'(s), run, lap, ex, wr});
        name_q.push_back(nm);
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            bus.tick = 1'b1;
            cyc();
        end
    endtask

    task automatic adj_ticks(int n);
        repeat (n) begin
            bus.adj_tick = 1'b1;
            cyc();
        end
    endtask

    task automatic pause_pulse();
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        cyc();
    endtask

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        bus.tick = 0; bus.adj_tick = 0; bus.pause_btn = 0; bus.lap_btn = 0;
        bus.adj = 0; bus.sel = 0; bus.down = 0;
        cyc(); cyc();
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        // up counting with minute carry
        pause_pulse();
        chk("run_start", 0, 0, 1, 0, 0, 0);
        ticks(60);
        chk("up60", 1, 0, 1, 0, 0, 0);
        ticks(1);
        chk("up61", 1, 1, 1, 0, 0, 0);
        // adjust: no carry between fields
        rst = 1'b1; cyc();
        chk("reset2", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bus.adj = 1; bus.sel = 0; cyc();
        adj_ticks(61);
        chk("adj_min", 1, 0, 0, 0, 0, 0);
        bus.sel = 1;
        adj_ticks(3);
        chk("adj_sec", 1, 3, 0, 0, 0, 0);
        bus.adj = 0; cyc();
        chk("adj_exit", 1, 3, 0, 0, 0, 0);
        // wrap from 59:59
        bus.adj = 1; bus.sel = 0;
        adj_ticks(58);
        bus.sel = 1;
        adj_ticks(56);
        chk("adj_5959", 59, 59, 0, 0, 0, 0);
        bus.adj = 0; cyc();
        pause_pulse();
        chk("run_5959", 59, 59, 1, 0, 0, 0);
        ticks(1);
        chk("wrap", 0, 0, 1, 0, 0, 1);
        cyc();
        chk("wrap_off", 0, 0, 1, 0, 0, 0);
        // countdown to expiry
        pause_pulse();
        chk("paused0", 0, 0, 0, 0, 0, 0);
        bus.adj = 1; bus.sel = 1;
        adj_ticks(2);
        bus.adj = 0; cyc();
        bus.down = 1;
        pause_pulse();
        chk("cd_run", 0, 2, 1, 0, 0, 0);
        ticks(1);
        chk("cd_1", 0, 1, 1, 0, 0, 0);
        ticks(1);
        chk("cd_done", 0, 0, 0, 0, 1, 0);
        ticks(2);
        chk("done_hold", 0, 0, 0, 0, 1, 0);
        pause_pulse();
        chk("done_clear", 0, 0, 0, 0, 0, 0);
        // lap freeze
        bus.down = 0;
        pause_pulse();
        ticks(10);
        chk("run10", 0, 10, 1, 0, 0, 0);
        bus.lap_btn = 1; cyc();
        chk("lap_on", 0, 10, 1, 1, 0, 0);
        bus.lap_btn = 0;
        ticks(5);
        chk("lap_frozen", 0, 10, 1, 1, 0, 0);
        bus.lap_btn = 1; cyc();
        chk("lap_off", 0, 15, 1, 0, 0, 0);
        bus.lap_btn = 0; cyc();
        // pause edge and tick together: tick dropped
        bus.pause_btn = 1; bus.tick = 1; cyc();
        chk("pause_tick", 0, 15, 0, 0, 0, 0);
        bus.pause_btn = 0; cyc();
        // button held through reset release
        rst = 1'b1; bus.pause_btn = 1; cyc();
        rst = 1'b0; cyc();
        chk("held_rst", 0, 0, 0, 0, 0, 0);
        bus.pause_btn = 0; cyc();
        // lap ignored in ADJ, reset wins in ADJ
        bus.adj = 1; bus.sel = 1;
        adj_ticks(5);
        chk("adj5", 0, 5, 0, 0, 0, 0);
        bus.lap_btn = 1; cyc();
        chk("adj_lap", 0, 5, 0, 0, 0, 0);
        bus.lap_btn = 0;
        rst = 1'b1; bus.adj_tick = 1; cyc();
        chk("rst_adj", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; bus.adj = 0; cyc();
        chk("post_rst", 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
- Parametrised successor to the board's min:sec stopwatch counter.
- Runs in one clock domain. Counting and adjust rates come from single-cycle enable strobes, not from derived clocks.
- Adds up/down (countdown timer) mode with an expiry flag, a lap-freeze display hold, a wrap pulse, and edge-detected pause toggling.
- Sits between the clock-divider strobes, the debounced buttons/switches, and the seven-segment display driver.

Parameters:
- W, 6, width of each field; 2^W >= max(SEC_MOD, MIN_MOD).
- SEC_MOD, 60, seconds-field modulus.
- MIN_MOD, 60, minutes-field modulus.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset (debounced reset button).
- tick  in  1  count strobe, one clk wide (1 Hz).
- adj_tick  in  1  adjust strobe, one clk wide (2 Hz).
- pause_btn  in  1  debounced level; each rising edge toggles run/pause.
- lap_btn  in  1  debounced level; each rising edge toggles lap freeze.
- adj  in  1  adjust-mode switch, level.
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds.
- down  in  1  count direction: 0 = up, 1 = down.
- min_out  out  W  displayed minutes.
- sec_out  out  W  displayed seconds.
- running  out  1  high in RUN.
- lapped  out  1  high while the display is frozen.
- expired  out  1  high in DONE.
- wrap  out  1  one-cycle pulse when an up-count rolls over from MIN_MOD-1:SEC_MOD-1 to 00:00.

Behaviour:
- All outputs are registered. Every state change takes effect on the clk edge following the qualifying input.
- Reset state:
  - min = 0, sec = 0, state PAUSED.
  - running = 0, lapped = 0, expired = 0, wrap = 0.
  - Edge-detect registers load the current pause_btn/lap_btn values, so a button held through reset produces no edge.
  - rst overrides every other input in any state, including mid-adjust and DONE.
- States: PAUSED, RUN, ADJ, DONE.
- Priority each cycle: rst > adj > pause edge > tick/adj_tick.
- Any state with adj = 1 goes to ADJ. Entering ADJ clears lapped and expired.
- ADJ:
  - On adj_tick, the selected field increments modulo its MOD. There is no carry between fields.
  - pause_btn, tick and down are ignored.
  - When adj falls, the next state is PAUSED.
- PAUSED: a pause edge goes to RUN. Counters hold.
- RUN:
  - A pause edge goes to PAUSED.
  - If a pause edge and tick arrive in the same cycle, the tick is dropped.
  - On tick, up mode: sec+1. At SEC_MOD, sec returns to 0 and min increments. At MIN_MOD, min returns to 0 and wrap pulses.
  - On tick, down mode: if already 00:00, go to DONE without decrementing. Otherwise decrement; sec 0 becomes SEC_MOD-1 with min-1. If the result is 00:00, go to DONE in the same edge.
- DONE:
  - Counters hold 00:00 and expired = 1. tick is ignored.
  - A pause edge goes to PAUSED and clears expired.
- down may change at any time. The new direction applies from the next tick.
- Lap:
  - A lap_btn rising edge toggles lapped in every state except ADJ, where it is ignored.
  - On 0→1, min_out/sec_out capture the current count and freeze. The internal count continues.
  - On 1→0, the outputs track the live count again on the same edge.
- Field values never exceed MOD-1, including after adjust wrap.

Test Plan:
- Reset, one pause edge, 61 ticks in up mode → running = 1, min_out = 1, sec_out = 1.
- Adjust: from PAUSED set adj = 1, sel = 0, apply 61 adj_ticks; then sel = 1, apply 3 → 01:03 with no carry; drop adj → PAUSED, still 01:03.
- Up-count wrap: adjust to 59:59, exit adj, run, one tick → 00:00 and wrap high for exactly one cycle.
- Countdown: set 00:02, down = 1, run → 00:01, then 00:00 with expired = 1 and running = 0; extra ticks leave 00:00; a pause edge clears expired.
- Lap: running at 00:10, lap edge, 5 ticks → outputs stay 00:10 while internal count reaches 00:15; second lap edge → outputs show 00:15.
- Corners:
  - pause edge + tick in the same cycle → count unchanged, PAUSED.
  - pause_btn held high through rst release → stays PAUSED.
  - rst asserted in ADJ → 00:00, PAUSED.
